counter_step_gen: RTL and testbench
===================================

// Module: counter_step_gen
// PURPOSE
//  Upstream stage of the LED counter: decides when the counter advances.
//  Emits single-cycle step pulses, either from a prescaler (auto mode, STEP_HZ) or one per
//  debounced press of a push button (manual mode); a second debounced button toggles mode.
//  Counter consumes step as its clock enable.
// PARAMETERS
//  CLK_FREQ     25_000_000  clk frequency in Hz
//  STEP_HZ      4           auto-mode step rate; DIV = CLK_FREQ/STEP_HZ (integer, DIV >= 2)
//  DEBOUNCE_MS  10          stable time; DB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS (>= 1)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous, active-low reset
//  btn_step   in   1  raw step button, active-high, asynchronous, bouncy
//  btn_mode   in   1  raw mode button, active-high, asynchronous, bouncy
//  step       out  1  registered single-cycle advance pulse to counter
//  auto_mode  out  1  1 = prescaler drives step, 0 = btn_step drives step
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): step=0, auto_mode=1, synchronisers=0,
//   debouncers in IDLE with count 0, prescaler=0. First activity after release of rst_n only.
//  Synchroniser: 2-FF per button; nothing downstream sees raw inputs.
//  Debouncer FSM (one per button, on synced level s, counter width ceil(log2(DB_CYCLES+1))):
//   IDLE     : s=1 -> PRESS_WAIT (count cleared)
//   PRESS_WAIT: s=0 -> IDLE; s=1 for DB_CYCLES consecutive cycles -> HELD, 1-cycle press event
//   HELD     : s=0 -> REL_WAIT (count cleared)
//   REL_WAIT : s=1 -> HELD; s=0 for DB_CYCLES consecutive cycles -> IDLE
//   Any bounce restarts the count; one event per debounced press; holding never repeats.
//  Latency: raw press held stable, first sampled high at edge k -> step (manual) high in
//   the cycle after edge k+DB_CYCLES+3; exactly one cycle wide. Same for mode toggle.
//  Mode: mode press event toggles auto_mode (registered, same edge as step would be).
//  Prescaler (auto_mode=1): count 0..DIV-1; at DIV-1 wraps to 0 and step=1 for one cycle.
//   Period exactly DIV cycles. In manual mode prescaler held at 0.
//   Entering auto mode clears prescaler; first auto step DIV cycles after the toggle edge.
//  Manual (auto_mode=0): each btn_step press event -> step=1 one cycle. btn_step events in
//   auto mode are discarded (not queued).
//  Simultaneous mode event and step source (prescaler wrap or step event) in same cycle:
//   mode toggles, step suppressed that cycle, prescaler cleared.
//  step never high two consecutive cycles (DIV >= 2, debounce spacing guarantees it).
// TESTING  (CLK_FREQ=1000, STEP_HZ=100 -> DIV=10, DEBOUNCE_MS=4 -> DB_CYCLES=4)
//  Reset, idle buttons 100 cycles -> auto_mode=1, step every 10th cycle, one cycle wide.
//  Clean btn_mode press held 20 cycles -> auto_mode=0 at DB_CYCLES+3=7 edges after sampling;
//   no further steps while buttons idle.
//  Manual: btn_step bounces 1-0-1-0 (2-cycle glitches) then holds 20 -> exactly one step,
//   7 edges after start of stable high; second press after 8+ cycles low -> second step.
//  Press btn_step in auto mode -> step pattern unchanged (still every 10 cycles, no extra).
//  Toggle back to auto -> first step exactly 10 cycles after auto_mode rises; mode event on
//   prescaler-wrap cycle -> no step that cycle.
//  Assert rst_n low mid-press and mid-prescale -> step=0, auto_mode=1 immediately; held button
//   after release needs full 4-cycle debounce before any event.

Source files
------------

// File: rtl/counter_step_gen.sv
// rtl/counter_step_gen.sv - step pulse source for the LED counter: prescaler or debounced button
// Two-FF synchronisers feed one debouncer per button; the mode event toggles auto/manual.

module counter_step_gen_db #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic press
);
  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic            press_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      press <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      press <= press_n;
    end
  end

  // Any change of level while waiting drops back and restarts the count.
  always_comb begin
    state_n = state;
    count_n = count;
    press_n = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_n = PRESS_WAIT;
          count_n = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_n = IDLE;
        end else if (count == CNT_LAST) begin
          state_n = HELD;
          count_n = '0;
          press_n = 1'b1;
        end else begin
          count_n = count + CW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_n = REL_WAIT;
          count_n = '0;
        end
      end
      REL_WAIT: begin
        if (s) begin
          state_n = HELD;
        end else if (count == CNT_LAST) begin
          state_n = IDLE;
          count_n = '0;
        end else begin
          count_n = count + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

module counter_step_gen #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int STEP_HZ     = 4,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  input  logic btn_mode,
  output logic step,
  output logic auto_mode
);
  localparam int DIV       = CLK_FREQ / STEP_HZ;
  localparam int DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int PW        = $clog2(DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic [1:0]    sync_step, sync_mode;
  logic          step_evt, mode_evt;
  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_step <= 2'b00;
      sync_mode <= 2'b00;
    end else begin
      sync_step <= {sync_step[0], btn_step};
      sync_mode <= {sync_mode[0], btn_mode};
    end
  end

  counter_step_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sync_step[1]),
    .press (step_evt)
  );

  counter_step_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (sync_mode[1]),
    .press (mode_evt)
  );

  // A mode event wins over any step source in the same cycle and restarts the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step      <= 1'b0;
      auto_mode <= 1'b1;
      presc     <= '0;
    end else if (mode_evt) begin
      step      <= 1'b0;
      auto_mode <= ~auto_mode;
      presc     <= '0;
    end else if (auto_mode) begin
      if (presc == DIV_LAST) begin
        presc <= '0;
        step  <= 1'b1;
      end else begin
        presc <= presc + PW'(1);
        step  <= 1'b0;
      end
    end else begin
      presc <= '0;
      step  <= step_evt;
    end
  end
endmodule

// File: tb/tb_counter_step_gen.sv
// tb/tb_counter_step_gen.sv - directed bench for counter_step_gen (DIV=10, DB_CYCLES=4)

module tb_counter_step_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_step = 1'b0;
  logic btn_mode = 1'b0;
  logic step;
  logic auto_mode;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int base = 0;
  int tog_at = -1;
  int man_at = -1;
  bit exp_auto = 1'b1;

  counter_step_gen #(
    .CLK_FREQ    (1000),
    .STEP_HZ     (100),
    .DEBOUNCE_MS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_step  (btn_step),
    .btn_mode  (btn_mode),
    .step      (step),
    .auto_mode (auto_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Expected step: auto mode every 10th edge after base, or a scheduled manual step.
  task automatic run(input int n);
    logic exp_step;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cyc == tog_at) begin
        exp_auto = !exp_auto;
        base     = cyc;
        tog_at   = -1;
        exp_step = 1'b0;
      end else begin
        exp_step = (cyc == man_at) ||
                   (exp_auto && cyc != base && ((cyc - base) % 10 == 0));
      end
      chk("step", step, exp_step);
      chk("auto_mode", auto_mode, exp_auto);
    end
  endtask

  // Raw press first sampled at edge cyc+1; debounced event lands 7 edges later.
  task automatic press_mode();
    btn_mode = 1'b1;
    tog_at   = cyc + 8;
  endtask

  task automatic release_rst();
    rst_n    = 1'b1;
    cyc      = 0;
    base     = 0;
    exp_auto = 1'b1;
    tog_at   = -1;
    man_at   = -1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset step", step, 1'b0);
    chk("reset auto_mode", auto_mode, 1'b1);
    release_rst();
    run(100);

    press_mode();
    run(20);
    btn_mode = 1'b0;
    run(30);

    btn_step = 1'b1; run(2);
    btn_step = 1'b0; run(2);
    btn_step = 1'b1; run(2);
    btn_step = 1'b0; run(2);
    btn_step = 1'b1;
    man_at   = cyc + 8;
    run(20);
    btn_step = 1'b0;
    run(10);
    btn_step = 1'b1;
    man_at   = cyc + 8;
    run(12);
    btn_step = 1'b0;
    run(12);

    press_mode();
    run(20);
    btn_mode = 1'b0;
    run(20);
    btn_step = 1'b1;
    run(20);
    btn_step = 1'b0;
    run(25);

    for (int i = 0; i < 10 && ((cyc - base) % 10 != 0); i++) run(1);
    chk("pre-reset step", step, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset step", step, 1'b0);
    chk("async reset auto_mode", auto_mode, 1'b1);
    repeat (3) tick();
    release_rst();
    run(25);

    for (int i = 0; i < 10 && ((cyc - base) % 10 != 2); i++) run(1);
    press_mode();
    run(20);
    btn_mode = 1'b0;
    run(20);

    press_mode();
    run(4);
    rst_n = 1'b0;
    #1;
    chk("mid-press reset step", step, 1'b0);
    chk("mid-press reset auto_mode", auto_mode, 1'b1);
    repeat (3) tick();
    release_rst();
    tog_at = 8;
    run(20);
    btn_mode = 1'b0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
